// File: rtl/data_memory_ctrl.sv
// Data memory controller: inferred word array, one-entry write buffer, RD_LAT-deep read pipeline.
// Build option DMEM_STORE_FWD_EN: merge buffered bytes into same-address reads instead of stalling.
module data_memory_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 19,
    parameter int RD_LAT = 1
) (
    input  logic                CLK,
    input  logic                reset_n,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic                distinct,
    input  logic [31:0]         address,
    input  logic [DATA_W-1:0]   write_data,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0]   read_data,
    output logic                read_valid,
    output logic                stall,
    output logic                err
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] req_addr;
    logic              hazard;
    logic              rd_accept;
    logic              wr_accept;

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [NB-1:0]     wb_be;

    logic [RD_LAT-1:0] pipe_vld;
    logic [DATA_W-1:0] pipe_word [RD_LAT];
    logic [DATA_W-1:0] out_word;

    assign req_addr = address[ADDR_W-1:0];

    generate
        if (ADDR_W < 32) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^address[31:ADDR_W];
        end
    endgenerate

    // A read of the buffered word would see stale array data: the buffer commits on the same edge.
    assign hazard = MemRead & wb_valid & (req_addr == wb_addr);

`ifdef DMEM_STORE_FWD_EN
    assign stall = 1'b0;
`else
    assign stall = hazard;
`endif

    assign rd_accept = MemRead & ~stall;
    assign wr_accept = MemWrite & distinct & ~MemRead & ~stall;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            wb_be    <= '0;
            err      <= 1'b0;
        end else begin
            wb_valid <= wr_accept;
            if (wr_accept) begin
                wb_addr <= req_addr;
                wb_data <= write_data;
                wb_be   <= byte_en;
            end
            if (MemRead & MemWrite & distinct)
                err <= 1'b1;
        end
    end

    // Array and read data path carry no reset; read-first since the read samples before the commit lands.
    always_ff @(posedge CLK) begin
        if (wb_valid) begin
            for (int b = 0; b < NB; b++) begin
                if (wb_be[b])
                    mem[wb_addr][b*8 +: 8] <= wb_data[b*8 +: 8];
            end
        end
        pipe_word[0] <= mem[req_addr];
        for (int i = 1; i < RD_LAT; i++)
            pipe_word[i] <= pipe_word[i-1];
    end

`ifdef DMEM_STORE_FWD_EN
    logic [DATA_W-1:0] hit_mask;
    logic [DATA_W-1:0] fwd_mask [RD_LAT];
    logic [DATA_W-1:0] fwd_data [RD_LAT];

    always_comb begin
        hit_mask = '0;
        for (int b = 0; b < NB; b++)
            hit_mask[b*8 +: 8] = {8{hazard & wb_be[b]}};
    end

    always_ff @(posedge CLK) begin
        fwd_mask[0] <= hit_mask;
        fwd_data[0] <= wb_data;
        for (int i = 1; i < RD_LAT; i++) begin
            fwd_mask[i] <= fwd_mask[i-1];
            fwd_data[i] <= fwd_data[i-1];
        end
    end

    assign out_word = (pipe_word[RD_LAT-1] & ~fwd_mask[RD_LAT-1]) |
                      (fwd_data[RD_LAT-1] & fwd_mask[RD_LAT-1]);
`else
    assign out_word = pipe_word[RD_LAT-1];
`endif

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld   <= '0;
            read_valid <= 1'b0;
            read_data  <= '0;
        end else begin
            pipe_vld[0] <= rd_accept;
            for (int i = 1; i < RD_LAT; i++)
                pipe_vld[i] <= pipe_vld[i-1];
            read_valid <= pipe_vld[RD_LAT-1];
            if (pipe_vld[RD_LAT-1])
                read_data <= out_word;
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: three instances (RD_LAT 1, 2, 4) share stimulus and a request-order memory model.
module tb_data_memory_ctrl;
    localparam int AW = 8;
    localparam int LATS [3] = '{1, 2, 4};

    logic        CLK = 1'b0;
    logic        reset_n;
    logic        MemRead, MemWrite, distinct;
    logic [31:0] address, write_data;
    logic [3:0]  byte_en;

    logic [31:0] rdat [3];
    logic        rvld [3];
    logic        stl  [3];
    logic        er   [3];

    int errors = 0;
    int checks = 0;

`ifdef DMEM_STORE_FWD_EN
    localparam logic HAZ_STALL = 1'b0;
`else
    localparam logic HAZ_STALL = 1'b1;
`endif

    always #5 CLK = ~CLK;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            data_memory_ctrl #(.DATA_W(32), .ADDR_W(AW), .RD_LAT(LATS[g])) u_dut (
                .CLK(CLK), .reset_n(reset_n), .MemRead(MemRead), .MemWrite(MemWrite),
                .distinct(distinct), .address(address), .write_data(write_data),
                .byte_en(byte_en), .read_data(rdat[g]), .read_valid(rvld[g]),
                .stall(stl[g]), .err(er[g]));
        end
    endgenerate

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Model: logical memory plus the one pending write; reads see every earlier accepted write.
    logic [31:0]    mmem [1 << AW];
    bit             pv;
    logic [AW-1:0]  pa;
    logic [31:0]    pd;
    logic [3:0]     pbe;
    bit             merr;
    logic [31:0]    last [3];
    bit             ev [int];
    logic [31:0]    ed [int];
    int             n = 0;

    initial begin
        pv = 0; merr = 0;
        for (int k = 0; k < 3; k++) last[k] = '0;
        forever begin
            @(negedge CLK);
            #4;
            n++;
            if (!reset_n) begin
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("rst rdata L%0d", LATS[k]), rdat[k], 32'h0);
                    chk($sformatf("rst rvalid L%0d", LATS[k]), {31'b0, rvld[k]}, 32'h0);
                    chk($sformatf("rst stall L%0d", LATS[k]), {31'b0, stl[k]}, 32'h0);
                    chk($sformatf("rst err L%0d", LATS[k]), {31'b0, er[k]}, 32'h0);
                    last[k] = '0;
                end
                pv = 0; merr = 0;
                ev.delete(); ed.delete();
            end else begin
                logic          hz, xs, racc, wacc;
                logic [AW-1:0] a;
                a = address[AW-1:0];
                for (int k = 0; k < 3; k++) begin
                    int  m;
                    bit  e;
                    m = n - 1 - LATS[k];
                    e = ev.exists(m);
                    chk($sformatf("rvalid L%0d", LATS[k]), {31'b0, rvld[k]}, {31'b0, e});
                    if (e) begin
                        chk($sformatf("rdata L%0d", LATS[k]), rdat[k], ed[m]);
                        last[k] = ed[m];
                    end else begin
                        chk($sformatf("rdata hold L%0d", LATS[k]), rdat[k], last[k]);
                    end
                    chk($sformatf("err L%0d", LATS[k]), {31'b0, er[k]}, {31'b0, merr});
                end
                hz = pv && MemRead && (a == pa);
                xs = hz && HAZ_STALL;
                for (int k = 0; k < 3; k++)
                    chk($sformatf("stall L%0d", LATS[k]), {31'b0, stl[k]}, {31'b0, xs});
                racc = MemRead && !xs;
                wacc = MemWrite && distinct && !MemRead && !xs;
                if (racc) begin
                    ev[n] = 1'b1;
                    ed[n] = hz ? merge(mmem[a], pd, pbe) : mmem[a];
                end
                if (pv) mmem[pa] = merge(mmem[pa], pd, pbe);
                pv = wacc;
                if (wacc) begin
                    pa = a; pd = write_data; pbe = byte_en;
                end
                if (MemRead && MemWrite && distinct) merr = 1;
            end
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic ds,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge CLK);
        MemRead = rd; MemWrite = wr; distinct = ds;
        address = a; write_data = d; byte_en = be;
    endtask

    task automatic idle(input int k);
        repeat (k) drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        drive(0, 1, 1, a, d, be);
    endtask

    // Requester holds a stalled read for one more cycle; a hazard stall never lasts longer.
    task automatic do_rd(input logic [31:0] a);
        drive(1, 0, 0, a, 32'h0, 4'h0);
        #1;
        if (stl[1]) drive(1, 0, 0, a, 32'h0, 4'h0);
    endtask

    task automatic lit_all(input string nm, input logic [31:0] exp);
        #2;
        for (int k = 0; k < 3; k++) chk($sformatf("%s L%0d", nm, LATS[k]), rdat[k], exp);
    endtask

    task automatic chk_zero(input string nm);
        for (int k = 0; k < 3; k++) begin
            chk({nm, " rdata"}, rdat[k], 32'h0);
            chk({nm, " rvalid"}, {31'b0, rvld[k]}, 32'h0);
            chk({nm, " stall"}, {31'b0, stl[k]}, 32'h0);
            chk({nm, " err"}, {31'b0, er[k]}, 32'h0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        MemRead = 0; MemWrite = 0; distinct = 0;
        address = 0; write_data = 0; byte_en = 0;
        repeat (3) @(negedge CLK);
        #1 chk_zero("reset");
        reset_n = 1'b1;

        do_wr(32'h0,  32'h0000000A, 4'hF);
        do_wr(32'h1,  32'h0000000B, 4'hF);
        do_wr(32'h2,  32'h0000000C, 4'hF);
        do_wr(32'h3,  32'h0000000D, 4'hF);
        do_wr(32'h5,  32'h55555555, 4'hF);
        do_wr(32'h20, 32'h11223344, 4'hF);
        do_wr(32'h30, 32'h00000005, 4'hF);
        do_wr(32'h40, 32'h00000000, 4'hF);
        idle(1);

        do_wr(32'h10, 32'hDEADBEEF, 4'hF);
        idle(1);
        do_rd(32'h10);
        idle(6);
        lit_all("req020 data", 32'hDEADBEEF);

        do_wr(32'h20, 32'hAABBCCDD, 4'h5);
        drive(1, 0, 0, 32'h20, 32'h0, 4'h0);
        #1 chk("req021 stall", {31'b0, stl[1]}, {31'b0, HAZ_STALL});
        if (stl[1]) drive(1, 0, 0, 32'h20, 32'h0, 4'h0);
        idle(6);
        lit_all("req021 merge", 32'h11BB33DD);

        drive(0, 1, 0, 32'h40, 32'hFFFFFFFF, 4'hF);
        idle(1);
        do_rd(32'h40);
        idle(6);
        lit_all("req023 data", 32'h0);
        chk("req023 err", {31'b0, er[1]}, 32'h0);

        do_rd(32'h0); do_rd(32'h1); do_rd(32'h2); do_rd(32'h3);
        idle(6);
        lit_all("req024 last", 32'h0000000D);

        do_wr(32'h105, 32'hAABBCCDD, 4'hC);
        do_rd(32'h205);
        idle(6);
        lit_all("wrap partial", 32'hAABB5555);

        do_wr(32'h10, 32'h01020304, 4'hF);
        do_rd(32'h0);
        do_rd(32'h310);
        idle(6);
        lit_all("write then read", 32'h01020304);

        drive(1, 1, 1, 32'h30, 32'hFFFFFFFF, 4'hF);
        do_rd(32'h30);
        idle(6);
        lit_all("req022 data", 32'h00000005);
        for (int k = 0; k < 3; k++) chk("req022 err", {31'b0, er[k]}, 32'h1);

        do_rd(32'h0);
        do_wr(32'h3, 32'h00000077, 4'hF);
        @(negedge CLK);
        reset_n = 1'b0;
        MemRead = 0; MemWrite = 0; distinct = 0;
        #1 chk_zero("req025");
        repeat (2) @(negedge CLK);
        #1 reset_n = 1'b1;
        do_rd(32'h3);
        idle(6);
        lit_all("req025 old word", 32'h0000000D);
        do_rd(32'h0);
        idle(6);
        lit_all("post reset read", 32'h0000000A);

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
